// File: rtl/serial_subtractor.sv
// Bit-serial, LSB-first unsigned subtractor.
// One full-subtractor cell and a borrow flip-flop process one bit per clock.
// An operation takes WIDTH SHIFT cycles followed by a single DONE cycle.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset_b,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   state_t           state_r;
   state_t           state_s;
   logic [WIDTH-1:0] sa_r;
   logic [WIDTH-1:0] sb_r;
   logic [WIDTH-1:0] sr_r;
   logic             borrow_r;
   logic [CW-1:0]    count_r;
   logic [1:0]       cell_s;
   logic             last_shift_s;

   // Full-subtractor cell: returns {borrow_next, difference_bit}.
   function automatic logic [1:0] fs_cell(input logic x, input logic y, input logic bin);
      logic d;
      logic bout;
      d    = x ^ y ^ bin;
      bout = (~x & y) | (~(x ^ y) & bin);
      return {bout, d};
   endfunction

   assign cell_s       = fs_cell(sa_r[0], sb_r[0], borrow_r);
   assign last_shift_s = (count_r == CW'(WIDTH - 1));

   // Next-state logic: DONE always falls back to IDLE, start only matters in IDLE.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_s = SHIFT;
            end else begin
               state_s = IDLE;
            end
         end
         SHIFT: begin
            if (last_shift_s) begin
               state_s = DONE;
            end else begin
               state_s = SHIFT;
            end
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clock or negedge reset_b) begin
      if (!reset_b) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Operand capture on acceptance and one serial step per SHIFT cycle; results hold otherwise.
   always_ff @(posedge clock or negedge reset_b) begin
      if (!reset_b) begin
         sa_r     <= {WIDTH{1'b0}};
         sb_r     <= {WIDTH{1'b0}};
         sr_r     <= {WIDTH{1'b0}};
         borrow_r <= 1'b0;
         count_r  <= {CW{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  sa_r     <= a;
                  sb_r     <= b;
                  borrow_r <= 1'b0;
                  count_r  <= {CW{1'b0}};
               end else begin
                  sa_r <= sa_r;
               end
            end
            SHIFT: begin
               sr_r     <= {cell_s[0], sr_r[WIDTH-1:1]};
               sa_r     <= {1'b0, sa_r[WIDTH-1:1]};
               sb_r     <= {1'b0, sb_r[WIDTH-1:1]};
               borrow_r <= cell_s[1];
               count_r  <= count_r + CW'(1);
            end
            default: begin
               sr_r <= sr_r;
            end
         endcase
      end
   end

   assign busy       = (state_r == SHIFT);
   assign done       = (state_r == DONE);
   assign diff       = sr_r;
   assign borrow_out = borrow_r;
   assign zero       = (sr_r == {WIDTH{1'b0}});

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomised scoreboard bench for serial_subtractor (WIDTH=8 plus an exhaustive WIDTH=4 instance).
module tb_serial_subtractor;

   localparam int W = 8;

   logic       clock = 1'b0;
   logic       reset_b;
   logic       start, start4;
   logic [7:0] a, b, diff;
   logic [3:0] a4, b4, diff4;
   logic       busy, done, borrow_out, zero;
   logic       busy4, done4, borrow_out4, zero4;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   typedef struct {
      logic [7:0] d;
      logic       bo;
      logic       z;
      int         done_cyc;
   } exp_t;

   typedef struct {
      logic [3:0] d;
      logic       bo;
      logic       z;
   } exp4_t;

   exp_t  q[$];
   exp4_t q4[$];
   int    done_times[$];

   serial_subtractor #(.WIDTH(8)) dut (
      .clock(clock), .reset_b(reset_b), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out), .zero(zero)
   );

   serial_subtractor #(.WIDTH(4)) dut4 (
      .clock(clock), .reset_b(reset_b), .start(start4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .diff(diff4), .borrow_out(borrow_out4), .zero(zero4)
   );

   always #5 clock = ~clock;

   // Cycle counter used to time-stamp accepting edges and done pulses.
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference: plain modular subtraction, unsigned compare for the borrow.
   function automatic exp_t model8(input logic [7:0] x, input logic [7:0] y, input int acc);
      exp_t e;
      e.d        = 8'(x - y);
      e.bo       = (x < y);
      e.z        = (e.d == 8'h00);
      e.done_cyc = acc + W;
      return e;
   endfunction

   function automatic exp4_t model4(input logic [3:0] x, input logic [3:0] y);
      exp4_t e;
      e.d  = 4'(x - y);
      e.bo = (x < y);
      e.z  = (e.d == 4'h0);
      return e;
   endfunction

   // Monitor for the 8-bit instance.
   initial begin
      int busy_run;
      exp_t e;
      busy_run = 0;
      forever begin
         @(negedge clock);
         if (!reset_b) begin
            busy_run = 0;
         end else begin
            chk("busy_done_exclusive", busy & done, 0);
            if (done) begin
               chk("done_expected", q.size() > 0, 1);
               if (q.size() > 0) begin
                  e = q.pop_front();
                  chk("diff", diff, e.d);
                  chk("borrow_out", borrow_out, e.bo);
                  chk("zero", zero, e.z);
                  chk("done_latency", cyc, e.done_cyc);
                  chk("busy_cycles", busy_run, W);
               end
               done_times.push_back(cyc);
               busy_run = 0;
            end else if (busy) begin
               busy_run++;
            end else begin
               busy_run = 0;
            end
         end
      end
   end

   // Monitor for the 4-bit instance.
   initial begin
      int busy_run;
      exp4_t e;
      busy_run = 0;
      forever begin
         @(negedge clock);
         if (reset_b && done4) begin
            chk("done4_expected", q4.size() > 0, 1);
            if (q4.size() > 0) begin
               e = q4.pop_front();
               chk("diff4", diff4, e.d);
               chk("borrow_out4", borrow_out4, e.bo);
               chk("zero4", zero4, e.z);
               chk("busy4_cycles", busy_run, 4);
            end
            busy_run = 0;
         end else if (reset_b && busy4) begin
            busy_run++;
         end else begin
            busy_run = 0;
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while ((busy || done) && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (n >= 50) chk("idle_timeout", n, 0);
   endtask

   task automatic wait_idle4();
      int n = 0;
      while ((busy4 || done4) && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (n >= 50) chk("idle4_timeout", n, 0);
   endtask

   task automatic run_op(input logic [7:0] x, input logic [7:0] y);
      wait_idle();
      a     = x;
      b     = y;
      start = 1'b1;
      q.push_back(model8(x, y, cyc + 1));
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() > 0 || q4.size() > 0) && n < 60) begin
         @(negedge clock);
         n++;
      end
      @(negedge clock);
      chk("queues_drained", q.size() + q4.size(), 0);
   endtask

   initial begin
      reset_b = 1'b0;
      start   = 1'b0;
      start4  = 1'b0;
      a = 8'h00; b = 8'h00; a4 = 4'h0; b4 = 4'h0;
      #3;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_diff", diff, 0);
      chk("rst_borrow", borrow_out, 0);
      chk("rst_zero", zero, 1);
      chk("rst_diff4", diff4, 0);
      repeat (2) @(negedge clock);
      reset_b = 1'b1;
      @(negedge clock);

      // Directed and boundary operands.
      run_op(8'h05, 8'h03);
      run_op(8'h03, 8'h05);
      run_op(8'h00, 8'h01);
      run_op(8'hA5, 8'hA5);
      run_op(8'hFF, 8'h00);
      run_op(8'h00, 8'h00);
      run_op(8'h00, 8'hFF);
      run_op(8'hFF, 8'hFF);

      // Start and operand changes while shifting must be ignored.
      run_op(8'h5A, 8'h3C);
      repeat (2) @(negedge clock);
      start = 1'b1; a = 8'hFF; b = 8'h11;
      @(negedge clock);
      start = 1'b0;
      a = 8'h22;
      drain();

      // Reset after four shifts aborts with no done pulse.
      wait_idle();
      a = 8'hC3; b = 8'h4E; start = 1'b1;
      @(posedge clock);
      repeat (4) @(posedge clock);
      #2;
      reset_b = 1'b0;
      start   = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_diff", diff, 0);
      chk("abort_borrow", borrow_out, 0);
      chk("abort_zero", zero, 1);
      @(negedge clock);
      reset_b = 1'b1;
      repeat (12) @(negedge clock);
      run_op(8'h10, 8'h01);
      drain();

      // Start held high: three back-to-back operations, one per WIDTH+2 cycles.
      done_times.delete();
      wait_idle();
      start = 1'b1;
      for (int k = 0; k < 3; k++) begin
         a = 8'($urandom);
         b = 8'($urandom);
         q.push_back(model8(a, b, cyc + 1));
         if (k < 2) repeat (W + 2) @(negedge clock);
         else @(negedge clock);
      end
      start = 1'b0;
      drain();
      chk("held_done_count", done_times.size(), 3);
      if (done_times.size() == 3) begin
         chk("spacing_1", done_times[1] - done_times[0], W + 2);
         chk("spacing_2", done_times[2] - done_times[1], W + 2);
      end

      // Random operands.
      for (int i = 0; i < 20; i++) run_op(8'($urandom), 8'($urandom));
      drain();

      // Exhaustive 4-bit sweep.
      for (int x = 0; x < 16; x++) begin
         for (int y = 0; y < 16; y++) begin
            wait_idle4();
            a4     = 4'(x);
            b4     = 4'(y);
            start4 = 1'b1;
            q4.push_back(model4(4'(x), 4'(y)));
            @(negedge clock);
            start4 = 1'b0;
         end
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 clock  input  1  rising-edge system clock.
REQ-003 reset_b  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 a  input  WIDTH  minuend; captured on the accepting edge.
REQ-006 b  input  WIDTH  subtrahend; captured on the accepting edge.
REQ-007 busy  output  1  high while in SHIFT.
REQ-008 done  output  1  one-cycle pulse; result valid.
REQ-009 diff  output  WIDTH  result register, a - b modulo 2^WIDTH.
REQ-010 borrow_out  output  1  final borrow; 1 when a < b (unsigned).
REQ-011 zero  output  1  high when diff == 0 in the DONE cycle and afterwards.

Function
REQ-012 The block SHALL be a bit-serial, LSB-first subtractor: one full-subtractor cell plus a borrow flip-flop, with WIDTH-bit shift registers SA, SB and SR.
REQ-013 The FSM SHALL have states IDLE, SHIFT and DONE, plus a bit counter of ceil(log2(WIDTH+1)) bits.
REQ-014 IDLE with start=1 at a rising edge: load SA=a, SB=b, borrow=0, count=0, go to SHIFT; start=0: stay in IDLE.
REQ-015 Each SHIFT edge: d = SA[0]^SB[0]^borrow; borrow_next = (~SA[0]&SB[0]) | (~(SA[0]^SB[0])&borrow); SR shifts right with d entering the MSB; SA and SB shift right; count increments.
REQ-016 The edge that performs the WIDTH-th shift SHALL move the FSM to DONE; SR then holds the full difference and borrow holds borrow_out.
REQ-017 Latency: done SHALL be high for exactly the one cycle following the WIDTH-th shift edge, i.e. WIDTH clocks after the accepting edge.
REQ-018 DONE SHALL always return to IDLE on the next edge; start is ignored in DONE.
REQ-019 start SHALL be ignored while busy=1; a, b and start changes during SHIFT SHALL NOT affect the operation in progress.
REQ-020 diff, borrow_out and zero SHALL hold their DONE values until the next accepted start; their values during SHIFT are unspecified.
REQ-021 Back-to-back operation: start held high SHALL be accepted on the first IDLE edge after DONE, giving one operation per WIDTH+2 cycles.
REQ-022 busy SHALL be 1 exactly in SHIFT; busy and done SHALL never be high together.
REQ-023 Boundary operands (a==b, a=0, b=0, all-ones) SHALL follow REQ-015 with no special casing.

Reset
REQ-024 reset_b=0 SHALL immediately, independent of clock, force IDLE, count=0, borrow=0, SA=SB=SR=0, busy=0, done=0, diff=0 and borrow_out=0; zero SHALL read 1.
REQ-025 Reset asserted mid-SHIFT or in DONE SHALL abort the operation with no done pulse; the first edge after deassertion SHALL be treated as IDLE.

Verification (WIDTH=8)
REQ-026 a=0x05, b=0x03, one-cycle start -> busy for 8 cycles, done pulse at cycle 8 after the accepting edge, diff=0x02, borrow_out=0, zero=0.
REQ-027 a=0x03, b=0x05 -> diff=0xFE, borrow_out=1; a=0x00, b=0x01 -> diff=0xFF, borrow_out=1.
REQ-028 a=0xA5, b=0xA5 -> diff=0x00, borrow_out=0, zero=1; a=0xFF, b=0x00 -> diff=0xFF, borrow_out=0.
REQ-029 Second start pulse and changed a/b applied mid-SHIFT -> ignored; the result matches the original operands, with exactly one done pulse.
REQ-030 reset_b pulsed low at shift 4 -> outputs go to reset values asynchronously with no done pulse; a new start then computes 0x10-0x01 = 0x0F correctly.
REQ-031 start held high for 3 operations -> done pulses spaced exactly 10 cycles apart; an exhaustive 4-bit run (WIDTH=4, all 256 pairs) matches a reference subtraction model.
